pixel_replication_stream: RTL

Sequential nearest-neighbour upscaler for the coprocessor's zoom-in path. On a start pulse it walks the output frame in raster order, reads each source pixel from the input framebuffer through a one-cycle-latency read port, and replicates it 2^SHIFT_FACTOR times horizontally and vertically. Output pixels leave on a valid/ready stream with their output coordinates attached. It sits between the source image RAM and the output framebuffer writer.

---
 rtl/pixel_replication_stream.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pixel_replication_stream.sv
// Nearest-neighbour 2^s upscaler reading a 1-cycle-latency source RAM.
// Define PIXREP_LINE_BUF_EN to cache the first row of each replicated band.
module pixel_replication_stream #(
    parameter int IMG_WIDTH_IN  = 160,
    parameter int IMG_HEIGHT_IN = 120,
    parameter int PIXEL_W       = 8,
    parameter int ADDR_W        = 15,
    parameter int MAX_SHIFT     = 3,
    parameter int XW            = 11,
    parameter int YW            = 10
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               START,
    input  logic [1:0]         SHIFT_FACTOR,
    output logic               R_EN,
    output logic [ADDR_W-1:0]  R_ADDR,
    input  logic [PIXEL_W-1:0] R_DATA,
    output logic [PIXEL_W-1:0] PIXEL_OUT,
    output logic [XW-1:0]      X_OUT_COORD,
    output logic [YW-1:0]      Y_OUT_COORD,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic               FRAME_END,
    output logic               BUSY,
    output logic               DONE
);
    localparam int SXW = (IMG_WIDTH_IN > 1) ? $clog2(IMG_WIDTH_IN) : 1;
    localparam int SYW = (IMG_HEIGHT_IN > 1) ? $clog2(IMG_HEIGHT_IN) : 1;
    localparam logic [2:0] MAX_S = 3'((MAX_SHIFT > 3) ? 3 : MAX_SHIFT);
    localparam logic [SXW-1:0] X_LAST = SXW'(IMG_WIDTH_IN - 1);
    localparam logic [SYW-1:0] Y_LAST = SYW'(IMG_HEIGHT_IN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WT,
        S_EMIT,
        S_DONE
`ifdef PIXREP_LINE_BUF_EN
        , S_LB
`endif
    } state_t;

    state_t state_q, state_d;

    logic [1:0]     s_q, s_d;
    logic [SXW-1:0] src_x_q, src_x_d;
    logic [SYW-1:0] src_y_q, src_y_d;
    logic [2:0]     hrep_q, hrep_d;
    logic [2:0]     vrep_q, vrep_d;
    logic [XW-1:0]  x_d;
    logic [YW-1:0]  y_d;

    logic [2:0]        rep_max;
    logic              h_wrap;
    logic              row_wrap;
    logic              v_wrap;
    logic              last_beat;
    logic              last_d;
    logic [ADDR_W-1:0] addr_d;

    // Modulo-8 arithmetic makes 1<<3 wrap to 0, so s=3 yields 7.
    assign rep_max   = (3'd1 << s_q) - 3'd1;
    assign h_wrap    = (hrep_q == rep_max);
    assign row_wrap  = h_wrap && (src_x_q == X_LAST);
    assign v_wrap    = (vrep_q == rep_max);
    assign last_beat = row_wrap && v_wrap && (src_y_q == Y_LAST);

    assign last_d = (hrep_d == rep_max) && (vrep_d == rep_max)
                 && (src_x_d == X_LAST) && (src_y_d == Y_LAST);

    assign addr_d = ADDR_W'(src_y_d) * ADDR_W'(IMG_WIDTH_IN)
                  + ADDR_W'(src_x_d);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        src_x_d = src_x_q;
        src_y_d = src_y_q;
        hrep_d  = hrep_q;
        vrep_d  = vrep_q;
        x_d     = X_OUT_COORD;
        y_d     = Y_OUT_COORD;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_RD;
                    s_d     = ({1'b0, SHIFT_FACTOR} > MAX_S)
                            ? MAX_S[1:0] : SHIFT_FACTOR;
                    src_x_d = '0;
                    src_y_d = '0;
                    hrep_d  = '0;
                    vrep_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            S_RD: state_d = S_WT;
            S_WT: state_d = S_EMIT;
`ifdef PIXREP_LINE_BUF_EN
            S_LB: state_d = S_EMIT;
`endif
            S_EMIT: begin
                if (OUT_READY) begin
                    x_d    = X_OUT_COORD + XW'(1);
                    hrep_d = hrep_q + 3'd1;
                    if (h_wrap) begin
                        hrep_d  = '0;
                        src_x_d = src_x_q + SXW'(1);
                        state_d = S_RD;
                        if (row_wrap) begin
                            src_x_d = '0;
                            x_d     = '0;
                            y_d     = Y_OUT_COORD + YW'(1);
                            vrep_d  = vrep_q + 3'd1;
                            if (v_wrap) begin
                                vrep_d  = '0;
                                src_y_d = src_y_q + SYW'(1);
                            end
                        end
`ifdef PIXREP_LINE_BUF_EN
                        // Rows after the first of a band come from the cache.
                        if (vrep_d != 3'd0) state_d = S_LB;
`endif
                        if (last_beat) state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef PIXREP_LINE_BUF_EN
    logic [PIXEL_W-1:0] line_buf [IMG_WIDTH_IN];

    always_ff @(posedge CLK) begin
        if (state_q == S_WT && vrep_q == 3'd0)
            line_buf[src_x_q] <= R_DATA;
    end
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            s_q         <= '0;
            src_x_q     <= '0;
            src_y_q     <= '0;
            hrep_q      <= '0;
            vrep_q      <= '0;
            X_OUT_COORD <= '0;
            Y_OUT_COORD <= '0;
            R_EN        <= 1'b0;
            R_ADDR      <= '0;
            PIXEL_OUT   <= '0;
            OUT_VALID   <= 1'b0;
            FRAME_END   <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            src_x_q     <= src_x_d;
            src_y_q     <= src_y_d;
            hrep_q      <= hrep_d;
            vrep_q      <= vrep_d;
            X_OUT_COORD <= x_d;
            Y_OUT_COORD <= y_d;
            R_EN        <= (state_d == S_RD);
            if (state_d == S_RD) R_ADDR <= addr_d;
            if (state_q == S_WT) PIXEL_OUT <= R_DATA;
`ifdef PIXREP_LINE_BUF_EN
            if (state_q == S_LB) PIXEL_OUT <= line_buf[src_x_q];
`endif
            OUT_VALID   <= (state_d == S_EMIT);
            FRAME_END   <= (state_d == S_EMIT) && last_d;
            BUSY        <= (state_d != S_IDLE);
            DONE        <= (state_d == S_DONE);
        end
    end

endmodule
